// File: rtl/ghostbus_host_pkg.sv
// Shared FSM encodings, read-latency bounds and counter sizing for the ghostbus initiator.
package ghostbus_host_pkg;

    localparam int GBH_RDLY_MIN = 1;
    localparam int GBH_RDLY_MAX = 15;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef logic [2:0] gbh_state_t;

    function automatic int gbh_ctr_width(input int rdly);
        return $clog2(rdly + 1);
    endfunction

    function automatic bit gbh_rdly_ok(input int rdly);
        return (rdly >= GBH_RDLY_MIN) && (rdly <= GBH_RDLY_MAX);
    endfunction

endpackage

// File: rtl/ghostbus_host_ctr.sv
// Loadable down-counter; tc_o flags when the count equals the terminal value TC.
module ghostbus_host_ctr #(
    parameter int W  = 8,
    parameter int TC = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/ghostbus_host.sv
// Ghostbus initiator: valid/ready commands in, single-cycle bus strobes out, read data back
// on a valid/ready response stream with auto-incrementing burst reads.
//
// state | meaning
// IDLE  | ready for a command
// WRITE | gb_we strobe, one cycle
// READ  | gb_re strobe, one cycle
// WAIT  | waiting RDLY cycles for gb_din
// RESP  | rsp_valid held until the response handshake
module ghostbus_host
    import ghostbus_host_pkg::*;
#(
    parameter int AW   = 24,
    parameter int DW   = 32,
    parameter int LW   = 8,
    parameter int RDLY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din,
    output logic          busy
);

    localparam int CW = gbh_ctr_width(RDLY);

    if (!gbh_rdly_ok(RDLY)) begin : g_rdly_bad
        $error("ghostbus_host: RDLY must be within 1..15");
    end

    gbh_state_t    state_q, state_d;
    logic [AW-1:0] gb_addr_q, gb_addr_d;
    logic [DW-1:0] gb_dout_q, gb_dout_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic beat_load, beat_dec, beat_zero;
    logic lat_load, lat_dec, lat_tc;

    ghostbus_host_ctr #(
        .W  (LW),
        .TC (0)
    ) u_beat_ctr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (beat_load),
        .load_val_i (cmd_len),
        .dec_i      (beat_dec),
        .tc_o       (beat_zero)
    );

    // Terminal at 1 so that the capture edge lands exactly RDLY cycles after the strobe.
    ghostbus_host_ctr #(
        .W  (CW),
        .TC (1)
    ) u_lat_ctr (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (lat_load),
        .load_val_i (CW'(RDLY)),
        .dec_i      (lat_dec),
        .tc_o       (lat_tc)
    );

    always_comb begin
        state_d     = state_q;
        gb_addr_d   = gb_addr_q;
        gb_dout_d   = gb_dout_q;
        rsp_rdata_d = rsp_rdata_q;
        beat_load   = 1'b0;
        beat_dec    = 1'b0;
        lat_load    = 1'b0;
        lat_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    gb_addr_d = cmd_addr;
                    if (cmd_we) begin
                        gb_dout_d = cmd_wdata;
                        state_d   = ST_WRITE;
                    end else begin
                        beat_load = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                lat_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                lat_dec = 1'b1;
                if (lat_tc) begin
                    rsp_rdata_d = gb_din;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (beat_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_dec  = 1'b1;
                        gb_addr_d = gb_addr_q + AW'(1);
                        state_d   = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gb_addr_q   <= '0;
            gb_dout_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gb_addr_q   <= gb_addr_d;
            gb_dout_q   <= gb_dout_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Held off while rst is high so no command can be handshaken during reset.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE);
    assign gb_we     = (state_q == ST_WRITE);
    assign gb_re     = (state_q == ST_READ);
    assign gb_addr   = gb_addr_q;
    assign gb_dout   = gb_dout_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_last  = (state_q == ST_RESP) && beat_zero;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ghostbus_host.sv
// Directed and constrained-random checks for ghostbus_host against a small bus memory model.
module tb_ghostbus_host;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int LW   = 8;
    localparam int RDLY = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_din;
    logic          busy;

    ghostbus_host #(.AW(AW), .DW(DW), .LW(LW), .RDLY(RDLY)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .gb_addr   (gb_addr),
        .gb_dout   (gb_dout),
        .gb_we     (gb_we),
        .gb_re     (gb_re),
        .gb_din    (gb_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        return (idx == 16) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(idx));
    endfunction

    // Bus target: 128-word memory aliased over the address space, fixed read latency.
    logic [31:0]     mem [128];
    bit              mem_init_done = 1'b0;
    logic [31:0]     pipe_d [RDLY];
    logic [RDLY-1:0] pipe_v = '0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (gb_we) begin
            mem[gb_addr[6:0]] <= gb_dout;
        end
        pipe_v    <= {pipe_v[RDLY-2:0], gb_re};
        pipe_d[0] <= mem[gb_addr[6:0]];
        for (int i = 1; i < RDLY; i++) pipe_d[i] <= pipe_d[i-1];
    end

    assign gb_din = pipe_v[RDLY-1] ? pipe_d[RDLY-1] : 32'hBAD0_BAD0;

    int          both_cnt = 0;
    int          we_cnt   = 0;
    int          re_cnt   = 0;
    int          rv_cnt   = 0;
    logic [55:0] wr_seen [$];
    logic [23:0] re_seen [$];
    logic [32:0] rsp_seen [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (gb_we && gb_re) both_cnt++;
            if (gb_we) begin
                we_cnt++;
                wr_seen.push_back({gb_addr, gb_dout});
            end
            if (gb_re) begin
                re_cnt++;
                re_seen.push_back(gb_addr);
            end
            if (rsp_valid) rv_cnt++;
            if (rsp_valid && rsp_ready) rsp_seen.push_back({rsp_last, rsp_rdata});
        end
    end

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          t_acc;
    logic [31:0] shadow [128];
    logic [55:0] exp_wr [$];
    logic [32:0] exp_rsp [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [23:0] addr, input logic [31:0] wd,
                         input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_len   = len;
        t_acc     = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, rsp_valid, 1);
    endtask

    initial begin
        int          re_base, we_base, rv_base, rsp_base, wr_base, c0, n, lasts, i, guard;
        logic [31:0] burst_exp [4];
        logic        acc, c_we;
        logic [23:0] c_addr, a;
        logic [31:0] c_wd;
        logic [7:0]  c_len;

        for (int k = 0; k < 128; k++) shadow[k] = init_word(k);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();

        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_outs", {gb_we, gb_re, rsp_valid, rsp_last, busy}, 0);
        check_val("rst_data", {gb_addr, gb_dout, rsp_rdata}, 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_ready", cmd_ready, 1);

        // single write
        we_base = we_cnt;
        rv_base = rv_cnt;
        issue(1'b1, 24'h000040, 32'hDEAD_BEEF, 8'd0);
        shadow[64] = 32'hDEAD_BEEF;
        check_val("wr_we_t1", gb_we, 1);
        check_val("wr_addr", gb_addr, 24'h000040);
        check_val("wr_dout", gb_dout, 32'hDEAD_BEEF);
        check_val("wr_ready_t1", cmd_ready, 0);
        tick();
        check_val("wr_we_t2", gb_we, 0);
        check_val("wr_ready_t2", cmd_ready, 1);
        repeat (4) tick();
        check_val("wr_we_once", we_cnt - we_base, 1);
        check_val("wr_no_rsp", rv_cnt - rv_base, 0);

        // single read
        issue(1'b0, 24'h000010, 32'h0, 8'd0);
        check_val("rd_re_t1", gb_re, 1);
        check_val("rd_addr", gb_addr, 24'h000010);
        tick();
        check_val("rd_re_t2", gb_re, 0);
        tick();
        check_val("rd_valid_t3", rsp_valid, 0);
        tick();
        check_val("rd_valid_t4", rsp_valid, 1);
        check_val("rd_data", rsp_rdata, 32'h1234_5678);
        check_val("rd_last", rsp_last, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("rd_done", {rsp_valid, cmd_ready}, 2'b01);

        // burst across the address wrap, rsp_ready high early
        burst_exp[0] = 32'hC0DE_007E;
        burst_exp[1] = 32'hC0DE_007F;
        burst_exp[2] = 32'hC0DE_0000;
        burst_exp[3] = 32'hC0DE_0001;
        re_base   = re_seen.size();
        rsp_ready = 1'b1;
        issue(1'b0, 24'hFFFFFE, 32'h0, 8'd3);
        c0 = t_acc;
        for (int k = 0; k < 4; k++) begin
            wait_rsp("burst_to", 12);
            check_val("burst_gap", cyc - c0, (k == 0) ? 4 : 4);
            c0 = cyc;
            check_val("burst_data", rsp_rdata, burst_exp[k]);
            check_val("burst_last", rsp_last, (k == 3) ? 1 : 0);
            tick();
        end
        rsp_ready = 1'b0;
        check_val("burst_nre", re_seen.size() - re_base, 4);
        if (re_seen.size() - re_base == 4) begin
            check_val("burst_a0", re_seen[re_base],     24'hFFFFFE);
            check_val("burst_a1", re_seen[re_base + 1], 24'hFFFFFF);
            check_val("burst_a2", re_seen[re_base + 2], 24'h000000);
            check_val("burst_a3", re_seen[re_base + 3], 24'h000001);
        end

        // backpressure mid-burst
        issue(1'b0, 24'h000020, 32'h0, 8'd2);
        wait_rsp("bp_to0", 12);
        check_val("bp_d0", rsp_rdata, 32'hC0DE_0020);
        re_base = re_cnt;
        repeat (10) tick();
        check_val("bp_hold_valid", rsp_valid, 1);
        check_val("bp_hold_data", rsp_rdata, 32'hC0DE_0020);
        check_val("bp_hold_last", rsp_last, 0);
        check_val("bp_no_re", re_cnt - re_base, 0);
        rsp_ready = 1'b1;
        tick();
        for (int k = 1; k < 3; k++) begin
            wait_rsp("bp_to", 12);
            check_val("bp_data", rsp_rdata, 32'hC0DE_0020 + 32'(k));
            check_val("bp_last", rsp_last, (k == 2) ? 1 : 0);
            tick();
        end
        rsp_ready = 1'b0;

        // reset while waiting on read data
        issue(1'b0, 24'h000010, 32'h0, 8'd0);
        tick();
        re_base = re_cnt;
        rv_base = rv_cnt;
        rst = 1'b1;
        tick();
        check_val("mid_rst_ready", cmd_ready, 0);
        check_val("mid_rst_outs", {gb_we, gb_re, rsp_valid, rsp_last, busy}, 0);
        check_val("mid_rst_data", {gb_addr, gb_dout, rsp_rdata}, 0);
        rst = 1'b0;
        #1;
        check_val("mid_rst_ready1", cmd_ready, 1);
        rsp_ready = 1'b1;
        repeat (6) tick();
        rsp_ready = 1'b0;
        check_val("mid_rst_no_rsp", rv_cnt - rv_base, 0);
        check_val("mid_rst_no_re", re_cnt - re_base, 0);
        check_val("mid_rst_rdata", rsp_rdata, 0);

        // maximum burst length
        rsp_base  = rsp_seen.size();
        rsp_ready = 1'b1;
        issue(1'b0, 24'h000000, 32'h0, 8'hFF);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        check_val("max_done", busy, 0);
        check_val("max_beats", rsp_seen.size() - rsp_base, 256);
        lasts = 0;
        for (int k = rsp_base; k < rsp_seen.size(); k++) lasts += int'(rsp_seen[k][32]);
        check_val("max_nlast", lasts, 1);
        if (rsp_seen.size() - rsp_base == 256) begin
            check_val("max_first", rsp_seen[rsp_base], {1'b0, shadow[0]});
            check_val("max_final", rsp_seen[rsp_base + 255], {1'b1, shadow[127]});
        end

        // random command stream with random response backpressure
        wr_base  = wr_seen.size();
        rsp_base = rsp_seen.size();
        c_we   = 1'($urandom_range(0, 1));
        c_addr = 24'($urandom);
        c_wd   = $urandom;
        c_len  = 8'($urandom_range(0, 3));
        cmd_valid = 1'b1;
        cmd_we = c_we; cmd_addr = c_addr; cmd_wdata = c_wd; cmd_len = c_len;
        i = 0;
        guard = 0;
        while (i < 20 && guard < 5000) begin
            acc = cmd_ready;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
            if (acc) begin
                if (c_we) begin
                    exp_wr.push_back({c_addr, c_wd});
                    shadow[c_addr[6:0]] = c_wd;
                end else begin
                    for (int k = 0; k <= int'(c_len); k++) begin
                        a = c_addr + 24'(k);
                        exp_rsp.push_back({(k == int'(c_len)), shadow[a[6:0]]});
                    end
                end
                i++;
                c_we   = 1'($urandom_range(0, 1));
                c_addr = 24'($urandom);
                c_wd   = $urandom;
                c_len  = 8'($urandom_range(0, 3));
                cmd_we = c_we; cmd_addr = c_addr; cmd_wdata = c_wd; cmd_len = c_len;
                if (i >= 20) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check_val("rnd_ncmd", i, 20);
        guard = 0;
        while ((busy || (rsp_seen.size() - rsp_base) < exp_rsp.size()) && guard < 3000) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        rsp_ready = 1'b0;
        check_val("rnd_drain", busy, 0);
        check_val("rnd_nwr", wr_seen.size() - wr_base, exp_wr.size());
        for (int k = 0; k < exp_wr.size() && (wr_base + k) < wr_seen.size(); k++)
            check_val("rnd_wr", wr_seen[wr_base + k], exp_wr[k]);
        check_val("rnd_nrsp", rsp_seen.size() - rsp_base, exp_rsp.size());
        for (int k = 0; k < exp_rsp.size() && (rsp_base + k) < rsp_seen.size(); k++)
            check_val("rnd_rsp", rsp_seen[rsp_base + k], exp_rsp[k]);
        check_val("we_re_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
